// File: rtl/sprite_layer_engine.sv
// sprite_layer_engine: multi-sprite renderer with a three-stage pipeline.
// Stage 1 computes ROM addresses, stage 2 waits on the synchronous ROMs, and
// stage 3 picks the highest-priority opaque pixel and tracks collisions.
// Optional feature: define SPRITE_MIRROR_EN to add per-sprite horizontal flip.
module sprite_layer_engine #(
    parameter int                 NUM_SPRITES = 4,
    parameter int                 SPR_W       = 32,
    parameter int                 SPR_H       = 64,
    parameter int                 COORD_W     = 10,
    parameter int                 COLOR_W     = 12,
    parameter logic [COLOR_W-1:0] TRANSPARENT = '0,
    parameter int                 ADDR_W      = $clog2(SPR_W) + $clog2(SPR_H),
    parameter int                 ID_W        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [COORD_W-1:0]             pix_row,
    input  logic [COORD_W-1:0]             pix_col,
    input  logic                           video_on,
    input  logic                           frame_start,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_x,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_y,
    input  logic [NUM_SPRITES-1:0]         spr_en,
`ifdef SPRITE_MIRROR_EN
    input  logic [NUM_SPRITES-1:0]         spr_flip,
`endif
    output logic [NUM_SPRITES*ADDR_W-1:0]  rom_addr,
    input  logic [NUM_SPRITES*COLOR_W-1:0] rom_data,
    output logic [COLOR_W-1:0]             pix_out,
    output logic                           pix_hit,
    output logic [ID_W-1:0]                hit_id,
    output logic [NUM_SPRITES-1:0]         collision
);

    localparam int XW = $clog2(SPR_W);
    localparam int YW = $clog2(SPR_H);

    // Frame-stable copies of the sprite configuration.
    logic [NUM_SPRITES*COORD_W-1:0] shadow_x_q, shadow_x_d;
    logic [NUM_SPRITES*COORD_W-1:0] shadow_y_q, shadow_y_d;
    logic [NUM_SPRITES-1:0]         shadow_en_q, shadow_en_d;
`ifdef SPRITE_MIRROR_EN
    logic [NUM_SPRITES-1:0]         shadow_flip_q, shadow_flip_d;
`endif

    // Pipeline registers; in_box and video bits double as the valid flags.
    logic [NUM_SPRITES*ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [NUM_SPRITES-1:0]        in_box_s1_q, in_box_s1_d;
    logic [NUM_SPRITES-1:0]        in_box_s2_q, in_box_s2_d;
    logic                          video_s1_q, video_s1_d;
    logic                          video_s2_q, video_s2_d;
    logic [COLOR_W-1:0]            pix_out_q, pix_out_d;
    logic                          pix_hit_q, pix_hit_d;
    logic [ID_W-1:0]               hit_id_q, hit_id_d;
    logic [NUM_SPRITES-1:0]        acc_q, acc_d;
    logic [NUM_SPRITES-1:0]        collision_q, collision_d;

    // Stage-1 scratch values, one sprite at a time.
    logic [COORD_W:0]              dx, dy;
    logic [XW-1:0]                 col;

    // Stage-3 scratch values.
    logic [NUM_SPRITES-1:0]        opaque;
    logic [NUM_SPRITES-1:0]        event_bits;
    logic                          seen, multi;

    // Latch the sprite configuration only at frame boundaries to avoid tearing.
    always_comb begin
        shadow_x_d  = shadow_x_q;
        shadow_y_d  = shadow_y_q;
        shadow_en_d = shadow_en_q;
`ifdef SPRITE_MIRROR_EN
        shadow_flip_d = shadow_flip_q;
`endif
        if (frame_start) begin
            shadow_x_d  = spr_x;
            shadow_y_d  = spr_y;
            shadow_en_d = spr_en;
`ifdef SPRITE_MIRROR_EN
            shadow_flip_d = spr_flip;
`endif
        end
    end

    // Stage 1: signed offsets into each sprite box and the ROM address per sprite.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        rom_addr_d  = '0;
        in_box_s1_d = '0;
        dx          = '0;
        dy          = '0;
        col         = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            // Zero-extended subtraction: bit COORD_W is the sign, so a position
            // left of or above the sprite is never seen as a large positive offset.
            dx  = {1'b0, pix_col} - {1'b0, shadow_x_q[i*COORD_W +: COORD_W]};
            dy  = {1'b0, pix_row} - {1'b0, shadow_y_q[i*COORD_W +: COORD_W]};
            col = dx[XW-1:0];
`ifdef SPRITE_MIRROR_EN
            // SPR_W-1-dx within a power-of-two field is the bitwise inverse.
            if (shadow_flip_q[i]) begin
                col = ~dx[XW-1:0];
            end
`endif
            // Upper bits all zero means 0 <= offset < size (sign bit included).
            in_box_s1_d[i] = shadow_en_q[i] && (dx[COORD_W:XW] == '0) && (dy[COORD_W:YW] == '0);
            if (in_box_s1_d[i]) begin
                rom_addr_d[i*ADDR_W +: ADDR_W] = {dy[YW-1:0], col};
            end
        end
        in_box_s2_d = in_box_s1_q;
        video_s1_d  = video_on;
        video_s2_d  = video_s1_q;
    end

    // Stage 3: priority select of the lowest opaque index plus collision tracking.
    always_comb begin
        opaque     = '0;
        pix_out_d  = '0;
        pix_hit_d  = 1'b0;
        hit_id_d   = '0;
        seen       = 1'b0;
        multi      = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            opaque[i] = in_box_s2_q[i] && video_s2_q &&
                        (rom_data[i*COLOR_W +: COLOR_W] != TRANSPARENT);
            if (opaque[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
            end
        end
        // Walk downward so the lowest opaque index is the last one written.
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                pix_out_d = rom_data[i*COLOR_W +: COLOR_W];
                hit_id_d  = ID_W'(i);
                pix_hit_d = 1'b1;
            end
        end
        event_bits = multi ? opaque : '0;
        // An overlap on the frame_start cycle still belongs to the closing frame.
        if (frame_start) begin
            collision_d = acc_q | event_bits;
            acc_d       = '0;
        end else begin
            collision_d = collision_q;
            acc_d       = acc_q | event_bits;
        end
    end

    // All state, with synchronous reset flushing the pipeline and configuration.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            shadow_x_q  <= '0;
            shadow_y_q  <= '0;
            shadow_en_q <= '0;
`ifdef SPRITE_MIRROR_EN
            shadow_flip_q <= '0;
`endif
            rom_addr_q  <= '0;
            in_box_s1_q <= '0;
            in_box_s2_q <= '0;
            video_s1_q  <= 1'b0;
            video_s2_q  <= 1'b0;
            pix_out_q   <= '0;
            pix_hit_q   <= 1'b0;
            hit_id_q    <= '0;
            acc_q       <= '0;
            collision_q <= '0;
        end else begin
            shadow_x_q  <= shadow_x_d;
            shadow_y_q  <= shadow_y_d;
            shadow_en_q <= shadow_en_d;
`ifdef SPRITE_MIRROR_EN
            shadow_flip_q <= shadow_flip_d;
`endif
            rom_addr_q  <= rom_addr_d;
            in_box_s1_q <= in_box_s1_d;
            in_box_s2_q <= in_box_s2_d;
            video_s1_q  <= video_s1_d;
            video_s2_q  <= video_s2_d;
            pix_out_q   <= pix_out_d;
            pix_hit_q   <= pix_hit_d;
            hit_id_q    <= hit_id_d;
            acc_q       <= acc_d;
            collision_q <= collision_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pix_out   = pix_out_q;
    assign pix_hit   = pix_hit_q;
    assign hit_id    = hit_id_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_sprite_layer_engine.sv
// tb_sprite_layer_engine: directed stimulus for sprite_layer_engine with a
// behavioural sprite model feeding a scoreboard queue of expected pixels.
module tb_sprite_layer_engine;

    localparam int N    = 4;
    localparam int CW   = 10;
    localparam int COLW = 12;
    localparam int AW   = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [CW-1:0]     pix_row, pix_col;
    logic              video_on, frame_start;
    logic [N*CW-1:0]   spr_x, spr_y;
    logic [N-1:0]      spr_en;
    logic [N*AW-1:0]   rom_addr;
    logic [N*COLW-1:0] rom_data;
    logic [COLW-1:0]   pix_out;
    logic              pix_hit;
    logic [1:0]        hit_id;
    logic [N-1:0]      collision;
`ifdef SPRITE_MIRROR_EN
    logic [N-1:0]      spr_flip = '0;
`endif

    sprite_layer_engine dut (
        .clk        (clk),
        .reset      (reset),
        .pix_row    (pix_row),
        .pix_col    (pix_col),
        .video_on   (video_on),
        .frame_start(frame_start),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_en     (spr_en),
`ifdef SPRITE_MIRROR_EN
        .spr_flip   (spr_flip),
`endif
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix_out    (pix_out),
        .pix_hit    (pix_hit),
        .hit_id     (hit_id),
        .collision  (collision)
    );

    // Synchronous sprite ROMs: data valid one cycle after the address.
    logic [COLW-1:0] rom_mem [N][2048];
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            rom_data[i*COLW +: COLW] <= rom_mem[i][rom_addr[i*AW +: AW]];
        end
    end

    typedef struct {
        logic          hit;
        logic [1:0]    id;
        logic [11:0]   pix;
        logic [N-1:0]  ev;
    } exp_t;

    exp_t          exp_q[$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            m_x[N];
    int            m_y[N];
    bit            m_en[N];
    logic [N-1:0]  m_acc    = '0;
    logic [N-1:0]  m_coll   = '0;
    logic [N*AW-1:0] exp_addr = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_spr(input int i, input int x, input int y);
        spr_x[i*CW +: CW] = CW'(x);
        spr_y[i*CW +: CW] = CW'(y);
    endtask

    // One pixel clock: compare due outputs, drive the next pixel, update the model.
    task automatic step(input int row, input int col, input bit von = 1'b0,
                        input bit fs = 1'b0, input bit rst = 1'b0);
        exp_t            e;
        exp_t            ne;
        int              dx, dy;
        logic [N-1:0]    opq;
        logic [AW-1:0]   a;
        logic [COLW-1:0] dv[N];
        @(negedge clk);
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            m_acc = m_acc | e.ev;
            check("pix_hit", 64'(pix_hit), 64'(e.hit));
            check("hit_id",  64'(hit_id),  64'(e.id));
            check("pix_out", 64'(pix_out), 64'(e.pix));
        end
        check("rom_addr",  64'(rom_addr),  64'(exp_addr));
        check("collision", 64'(collision), 64'(m_coll));

        pix_row     = CW'(row);
        pix_col     = CW'(col);
        video_on    = von;
        frame_start = fs;
        reset       = rst;

        ne       = '{hit: 1'b0, id: 2'd0, pix: 12'h000, ev: '0};
        opq      = '0;
        exp_addr = '0;
        for (int i = 0; i < N; i++) begin
            dv[i] = '0;
            dx = col - m_x[i];
            dy = row - m_y[i];
            if (m_en[i] && dx >= 0 && dx < 32 && dy >= 0 && dy < 64) begin
                a = AW'(dy * 32 + dx);
                exp_addr[i*AW +: AW] = a;
                dv[i] = rom_mem[i][a];
                if (von && dv[i] != 12'h000) opq[i] = 1'b1;
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (opq[i]) begin
                ne.hit = 1'b1;
                ne.id  = 2'(i);
                ne.pix = dv[i];
            end
        end
        if ($countones(opq) >= 2) ne.ev = opq;

        if (rst) begin
            ne       = '{hit: 1'b0, id: 2'd0, pix: 12'h000, ev: '0};
            exp_addr = '0;
            for (int k = 0; k < exp_q.size(); k++) begin
                exp_q[k] = '{hit: 1'b0, id: 2'd0, pix: 12'h000, ev: '0};
            end
            m_acc  = '0;
            m_coll = '0;
            for (int i = 0; i < N; i++) begin
                m_x[i] = 0; m_y[i] = 0; m_en[i] = 1'b0;
            end
        end else if (fs) begin
            // The oldest queued pixel reaches the output on the frame_start edge.
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                m_coll = m_acc | e.ev;
                e.ev = '0;
                exp_q[0] = e;
            end else begin
                m_coll = m_acc;
            end
            m_acc = '0;
            for (int i = 0; i < N; i++) begin
                m_x[i]  = int'(spr_x[i*CW +: CW]);
                m_y[i]  = int'(spr_y[i*CW +: CW]);
                m_en[i] = spr_en[i];
            end
        end
        exp_q.push_back(ne);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; pix_row = '0; pix_col = '0; video_on = 1'b0; frame_start = 1'b0;
        spr_x = '0; spr_y = '0; spr_en = '0;
        for (int i = 0; i < N; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_en[i] = 1'b0;
            for (int a = 0; a < 2048; a++) rom_mem[i][a] = {4'(i + 1), 8'(a)};
        end
        rom_mem[0][0]  = 12'hF00;
        rom_mem[0][33] = 12'h000;   // transparent at (dy=1, dx=1) of sprite 0

        // Reset state.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("reset_pix_out", 64'(pix_out), 64'h0);
        check("reset_pix_hit", 64'(pix_hit), 64'h0);

        // Frame A: sprite 0 at (305,405), sprite 3 near the right edge.
        set_spr(0, 305, 405); set_spr(3, 1010, 470); spr_en = 4'b1001;
        step(0, 0, 0, 1);
        step(405, 305, 1);      // corner hit, F00
        step(405, 337, 1);      // dx=32, outside
        step(405, 304, 1);      // dx=-1, outside
        step(405, 336, 1);      // dx=31, last column
        step(468, 305, 1);      // dy=63, last row
        step(469, 305, 1);      // dy=64, outside
        step(470, 1023, 1);     // clipped sprite 3, visible part
        step(470, 2, 1);        // no wrap-around
        step(405, 305, 0);      // blanking: address but no hit
        idle(4);

        // Frame B: sprites 0 and 1 stacked at (100,100).
        set_spr(0, 100, 100); set_spr(1, 100, 100); spr_en = 4'b0011;
        step(0, 0, 0, 1);
        step(100, 100, 1);      // both opaque: sprite 0 wins
        step(101, 101, 1);      // sprite 0 transparent: sprite 1 wins
        set_spr(0, 200, 100);   // mid-frame move is deferred
        step(100, 100, 1);
        step(100, 200, 1);
        set_spr(2, 110, 100); spr_en = 4'b0111;
        idle(4);

        // Frame C: collision 0011 from B; sprite 0 now at x=200; 1 and 2 overlap.
        step(0, 0, 0, 1);
        step(100, 200, 1);
        step(105, 115, 1);
        step(105, 100, 1);
        spr_en = 4'b0001;
        idle(4);

        // Frame D: collision 0110 from C; no overlap this frame.
        step(0, 0, 0, 1);
        step(100, 200, 1);
        idle(4);
        set_spr(1, 200, 100); spr_en = 4'b0011;

        // Frame E: collision 0; overlap lands exactly on the next frame_start edge.
        step(0, 0, 0, 1);
        step(100, 200, 1);
        step(0, 0);
        step(0, 0, 0, 1);       // frame F: collision 0011
        idle(4);
        step(0, 0, 0, 1);       // frame G: collision 0

        // Reset mid-frame with hits in flight.
        step(100, 200, 1);
        step(100, 201, 1);
        step(100, 202, 1, 0, 1);
        step(100, 200, 1);
        step(100, 200, 1);
        step(100, 200, 1);
        idle(3);
        step(0, 0, 0, 1);       // sprites return after frame_start
        step(100, 200, 1);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
